// File: rtl/altera_tse_xcvr_resync_pkg.sv
`default_nettype none
// ============================================================================
// Module      : altera_tse_xcvr_resync_pkg
// Description : Shared helpers for the transceiver-status resynchronisers:
//               constant clog2, synchroniser-length clamp and filter
//               counter width derivation.
// Revision    : 1.0 - initial release
// ============================================================================
package altera_tse_xcvr_resync_pkg;

    // Ceiling log2; returns 0 for inputs <= 1.
    function automatic int clog2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // A synchroniser needs at least one flop.
    function automatic int int_len(input int len);
        return (len < 1) ? 1 : len;
    endfunction

    // Counter must hold 0..FILTER_CYCLES-1; never narrower than one bit.
    function automatic int cnt_width(input int filter_cycles);
        int w;
        w = clog2(filter_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/altera_tse_xcvr_resync_filter_chan.sv
`default_nettype none
// ============================================================================
// Module      : altera_tse_xcvr_resync_filter_chan
// Description : One channel of the resync filter: metastability chain,
//               stability counter, filtered level and edge flags.
//               Optional macro ALTERA_TSE_XCVR_RESYNC_FILTER_STICKY_EN turns
//               rise/fall into sticky flags cleared by status_clr_i.
// Ports       : clk          - destination clock
//               reset_n      - synchronous active-low reset
//               d_i          - asynchronous input bit
//               status_clr_i - clear for sticky flags (sticky build only)
//               q_o          - filtered synchronised level
//               rise_o       - rising edge of q_o
//               fall_o       - falling edge of q_o
// Revision    : 1.0 - initial release
// ============================================================================
module altera_tse_xcvr_resync_filter_chan
    import altera_tse_xcvr_resync_pkg::*;
#(
    parameter int   SYNC_CHAIN_LENGTH = 2,
    parameter int   FILTER_CYCLES     = 4,
    parameter logic INIT_VALUE        = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    input  logic status_clr_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int INT_LEN = int_len(SYNC_CHAIN_LENGTH);

    logic [INT_LEN-1:0] sync_q;
    logic               sync_out;
    logic               level_q;
    logic               level_d;
    logic               rise_q;
    logic               rise_d;
    logic               fall_q;
    logic               fall_d;
    logic               rise_edge;
    logic               fall_edge;

    // ------------------------------------------------------------------
    // Metastability chain; bit 0 captures the asynchronous input.
    // ------------------------------------------------------------------
    generate
        if (INT_LEN == 1) begin : g_chain_single
            always_ff @(posedge clk) begin
                if (!reset_n) sync_q <= INIT_VALUE;
                else          sync_q <= d_i;
            end
        end else begin : g_chain_multi
            always_ff @(posedge clk) begin
                if (!reset_n) sync_q <= {INT_LEN{INIT_VALUE}};
                else          sync_q <= {sync_q[INT_LEN-2:0], d_i};
            end
        end
    endgenerate

    assign sync_out = sync_q[INT_LEN-1];

    // ------------------------------------------------------------------
    // Stability filter: level follows sync_out only after it has
    // disagreed for FILTER_CYCLES consecutive cycles.
    // ------------------------------------------------------------------
    generate
        if (FILTER_CYCLES == 0) begin : g_nofilt
            always_comb level_d = sync_out;
        end else begin : g_filt
            localparam int             CNT_W    = cnt_width(FILTER_CYCLES);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;

            always_comb begin
                level_d = level_q;
                cnt_d   = '0;
                if (sync_out != level_q) begin
                    if (cnt_q == CNT_LAST) level_d = sync_out;
                    else                   cnt_d   = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (!reset_n) cnt_q <= '0;
                else          cnt_q <= cnt_d;
            end
        end
    endgenerate

    assign rise_edge =  level_d & ~level_q;
    assign fall_edge = ~level_d &  level_q;

`ifdef ALTERA_TSE_XCVR_RESYNC_FILTER_STICKY_EN
    // A new edge overrides a simultaneous clear.
    assign rise_d = rise_edge | (rise_q & ~status_clr_i);
    assign fall_d = fall_edge | (fall_q & ~status_clr_i);
`else
    logic unused_status_clr;
    assign unused_status_clr = status_clr_i;
    assign rise_d = rise_edge;
    assign fall_d = fall_edge;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            level_q <= INIT_VALUE;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign q_o    = level_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule
`default_nettype wire

// File: rtl/altera_tse_xcvr_resync_filter.sv
`default_nettype none
// ============================================================================
// Module      : altera_tse_xcvr_resync_filter
// Description : Multi-channel resynchroniser with per-channel glitch filter
//               and edge detection, clocked in the destination domain.
//               Optional macro ALTERA_TSE_XCVR_RESYNC_FILTER_STICKY_EN makes
//               rise/fall sticky until status_clr.
// Ports       : clk        - destination clock
//               reset_n    - synchronous active-low reset
//               d          - asynchronous inputs, one per channel
//               status_clr - per-channel sticky-flag clear
//               q          - filtered synchronised levels
//               rise/fall  - per-channel edge indications
//               changed    - OR of all rise|fall bits
// Revision    : 1.0 - initial release
// ============================================================================
module altera_tse_xcvr_resync_filter
    import altera_tse_xcvr_resync_pkg::*;
#(
    parameter int               SYNC_CHAIN_LENGTH = 2,
    parameter int               WIDTH             = 1,
    parameter int               FILTER_CYCLES     = 4,
    parameter logic [WIDTH-1:0] INIT_VALUE        = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] status_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_chan
            altera_tse_xcvr_resync_filter_chan #(
                .SYNC_CHAIN_LENGTH (SYNC_CHAIN_LENGTH),
                .FILTER_CYCLES     (FILTER_CYCLES),
                .INIT_VALUE        (INIT_VALUE[i])
            ) u_chan (
                .clk          (clk),
                .reset_n      (reset_n),
                .d_i          (d[i]),
                .status_clr_i (status_clr[i]),
                .q_o          (q[i]),
                .rise_o       (rise[i]),
                .fall_o       (fall[i])
            );
        end
    endgenerate

    // rise/fall are flop outputs, so this OR is aligned with them.
    assign changed = |(rise | fall);

endmodule
`default_nettype wire
